// File: rtl/weight_loader_pkg.sv
// Shared definitions for the layer weight loaders: FSM encoding and default word/address widths.
package weight_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wl_state_t;

  localparam int WL_W_DEFAULT          = 8;
  localparam int WL_ADDR_WIDTH_DEFAULT = 15;

endpackage

// File: rtl/wl_rd_valid_pipe.sv
// Tracks in-flight BRAM reads: DEPTH-deep 1-bit shift register, issue strobe in, capture strobe out.
// Latency: DEPTH cycles. No backpressure; one strobe per cycle always advances.
module wl_rd_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_vld,
  output logic capture_vld
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = issue_vld;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign capture_vld = pipe_q[DEPTH-1];

endmodule

// File: rtl/weight_loader_multi.sv
// Loads num_words BRAM words from base_addr into a packed register bus; optional checksum (WL_CHECKSUM_EN).
// Latency: done rises n+RD_LAT edges after the accepting edge (1 edge when n==0).
// No backpressure: one read per cycle; start is ignored while a load is in flight.
module weight_loader_multi
  import weight_loader_pkg::*;
#(
  parameter int W          = WL_W_DEFAULT,
  parameter int MAX_WORDS  = 640,
  parameter int ADDR_WIDTH = WL_ADDR_WIDTH_DEFAULT,
  parameter int RD_LAT     = 2,
  parameter int CNT_WIDTH  = $clog2(MAX_WORDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [CNT_WIDTH-1:0]   num_words,
  output logic                   bram_en,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  input  logic [W-1:0]           bram_dout,
  output logic [MAX_WORDS*W-1:0] data_out,
  output logic [CNT_WIDTH-1:0]   word_count,
  output logic                   busy,
  output logic                   done
`ifdef WL_CHECKSUM_EN
  ,
  output logic [W+CNT_WIDTH-1:0] checksum
`endif
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WORDS);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  wl_state_t              state_q, state_d;
  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]   issued_q, issued_d;
  logic [CNT_WIDTH-1:0]   word_count_q, word_count_d;
  logic                   bram_en_q, bram_en_d;
  logic [ADDR_WIDTH-1:0]  bram_addr_q, bram_addr_d;
  logic [MAX_WORDS*W-1:0] data_out_q, data_out_d;
  logic [CNT_WIDTH-1:0]   len_clamp;
  logic                   accept;
  logic                   capture;
  logic                   last_capture;

  // The pipe is fed by the registered enable, i.e. the cycle the address is actually on the port.
  wl_rd_valid_pipe #(
    .DEPTH(RD_LAT)
  ) u_rd_valid_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue_vld  (bram_en_q),
    .capture_vld(capture)
  );

  assign len_clamp    = (num_words > MAX_CNT) ? MAX_CNT : num_words;
  assign accept       = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_capture = capture && (word_count_q == (len_q - ONE_CNT));

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    issued_d     = issued_q;
    bram_en_d    = bram_en_q;
    bram_addr_d  = bram_addr_q;
    data_out_d   = data_out_q;
    word_count_d = word_count_q;

    if (capture) begin
      data_out_d[word_count_q*W +: W] = bram_dout;
      word_count_d = word_count_q + ONE_CNT;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          len_d        = len_clamp;
          data_out_d   = '0;
          word_count_d = '0;
          bram_addr_d  = base_addr;
          if (len_clamp == '0) begin
            state_d   = ST_DONE;
            bram_en_d = 1'b0;
            issued_d  = '0;
          end else begin
            state_d   = ST_READ;
            bram_en_d = 1'b1;
            issued_d  = ONE_CNT;
          end
        end
      end
      ST_READ: begin
        // issued counts addresses already on the port; stop once all n are out.
        if (issued_q == len_q) begin
          bram_en_d = 1'b0;
          state_d   = ST_DRAIN;
        end else begin
          bram_addr_d = bram_addr_q + ADDR_WIDTH'(1);
          issued_d    = issued_q + ONE_CNT;
        end
      end
      ST_DRAIN: begin
        if (last_capture) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      word_count_q <= '0;
      bram_en_q    <= 1'b0;
      bram_addr_q  <= '0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      word_count_q <= word_count_d;
      bram_en_q    <= bram_en_d;
      bram_addr_q  <= bram_addr_d;
      data_out_q   <= data_out_d;
    end
  end

`ifdef WL_CHECKSUM_EN
  logic [W+CNT_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (accept) begin
      checksum_d = '0;
    end else if (capture) begin
      checksum_d = checksum_q + (W+CNT_WIDTH)'(bram_dout);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  assign bram_en    = bram_en_q;
  assign bram_addr  = bram_addr_q;
  assign data_out   = data_out_q;
  assign word_count = word_count_q;
  assign busy       = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_weight_loader_multi.sv
// Bench for weight_loader_multi: three instances (RD_LAT 1,2,3) share stimulus, each with its own BRAM model.
module tb_weight_loader_multi;

  localparam int W         = 8;
  localparam int MAX_WORDS = 640;
  localparam int AW        = 15;
  localparam int CW        = 10;
  localparam int DW        = MAX_WORDS * W;
  localparam int NI        = 3;
  localparam int MEMSZ     = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_words;

  logic          bram_en    [NI];
  logic [AW-1:0] bram_addr  [NI];
  logic [W-1:0]  bram_dout  [NI];
  logic [DW-1:0] data_out   [NI];
  logic [CW-1:0] word_count [NI];
  logic          busy       [NI];
  logic          done       [NI];
`ifdef WL_CHECKSUM_EN
  logic [W+CW-1:0] checksum [NI];
`endif

  logic [W-1:0]  mem      [MEMSZ];
  logic [W-1:0]  pipe     [NI][4];
  logic [AW-1:0] addr_log [NI][1024];
  int            addr_cnt [NI];
  logic          log_clr;

  int checks   = 0;
  int failures = 0;

  // BRAM models: latency g+1 for instance g; also log every issued address.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      pipe[g][0] <= bram_en[g] ? mem[bram_addr[g]] : 'x;
      for (int i = 1; i < 4; i++) pipe[g][i] <= pipe[g][i-1];
      if (log_clr) begin
        addr_cnt[g] <= 0;
      end else if (bram_en[g]) begin
        if (addr_cnt[g] < 1024) addr_log[g][addr_cnt[g]] <= bram_addr[g];
        addr_cnt[g] <= addr_cnt[g] + 1;
      end
    end
  end

  always_comb begin
    for (int g = 0; g < NI; g++) bram_dout[g] = pipe[g][g];
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    weight_loader_multi #(
      .W(W), .MAX_WORDS(MAX_WORDS), .ADDR_WIDTH(AW), .RD_LAT(g + 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .num_words  (num_words),
      .bram_en    (bram_en[g]),
      .bram_addr  (bram_addr[g]),
      .bram_dout  (bram_dout[g]),
      .data_out   (data_out[g]),
      .word_count (word_count[g]),
      .busy       (busy[g]),
      .done       (done[g])
`ifdef WL_CHECKSUM_EN
      ,
      .checksum   (checksum[g])
`endif
    );
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({bram_en[g], bram_addr[g], word_count[g], busy[g], done[g]} !== '0 || data_out[g] !== '0) begin
        failures++;
        $display("FAIL reset_state inst=%0d en=%0b addr=%0d cnt=%0d busy=%0b done=%0b required all zero",
                 g, bram_en[g], bram_addr[g], word_count[g], busy[g], done[g]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({bram_en[g], busy[g], done[g]} !== 3'b000) begin
        failures++;
        $display("FAIL idle_quiet inst=%0d en=%0b busy=%0b done=%0b required 0", g, bram_en[g], busy[g], done[g]);
      end
    end
  endtask

  // fill: 0 = mem[a]=a[7:0], 1 = all 8'hFF, 2 = random, 3 = keep.
  // glitch: edge after accept on which a stray start is pulsed (-1 = none).
  task automatic test_load(input int b, input int n, input int glitch, input int fill);
    int              ne, exp_edge, bad, k0;
    int              dedge [NI];
    bit              all_done;
    logic [DW-1:0]   exp_d;
    logic [W+CW-1:0] exp_sum;
    logic [AW-1:0]   ea;

    for (int a = 0; a < MEMSZ; a++) begin
      if (fill == 0) mem[a] = a[7:0];
      else if (fill == 1) mem[a] = 8'hFF;
      else if (fill == 2) mem[a] = 8'($urandom);
    end

    ne      = (n > MAX_WORDS) ? MAX_WORDS : n;
    exp_d   = '0;
    exp_sum = '0;
    for (int k = 0; k < ne; k++) begin
      exp_d[k*W +: W] = mem[(b + k) % MEMSZ];
      exp_sum         = exp_sum + (W+CW)'(mem[(b + k) % MEMSZ]);
    end

    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(b);
    num_words = CW'(n);
    log_clr   = 1'b1;
    for (int g = 0; g < NI; g++) dedge[g] = -1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    log_clr = 1'b0;

    for (int e = 1; e <= 1200; e++) begin
      @(posedge clk);
      #1;
      if (e == glitch) begin
        start     = 1'b1;
        base_addr = AW'(b + 77);
        num_words = CW'(3);
      end else if (e == glitch + 1) begin
        start = 1'b0;
      end
      all_done = 1'b1;
      for (int g = 0; g < NI; g++) begin
        if (done[g] === 1'b1 && dedge[g] < 0) dedge[g] = e;
        if (dedge[g] < 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    start = 1'b0;

    for (int g = 0; g < NI; g++) begin
      exp_edge = (ne == 0) ? 1 : ne + g + 1;
      checks++;
      if (dedge[g] != exp_edge) begin
        failures++;
        $display("FAIL done_latency inst=%0d base=%0d n=%0d got_edge=%0d required=%0d (-1 = timeout)",
                 g, b, n, dedge[g], exp_edge);
      end
      checks++;
      if (data_out[g] !== exp_d) begin
        failures++;
        k0 = 0;
        for (int k = MAX_WORDS - 1; k >= 0; k--) if (data_out[g][k*W +: W] !== exp_d[k*W +: W]) k0 = k;
        $display("FAIL data_out inst=%0d base=%0d n=%0d word=%0d got=%h required=%h",
                 g, b, n, k0, data_out[g][k0*W +: W], exp_d[k0*W +: W]);
      end
      checks++;
      if (word_count[g] !== CW'(ne) || busy[g] !== 1'b0 || done[g] !== 1'b1) begin
        failures++;
        $display("FAIL final_status inst=%0d cnt=%0d busy=%0b done=%0b required cnt=%0d busy=0 done=1",
                 g, word_count[g], busy[g], done[g], ne);
      end
      bad = -1;
      for (int i = 0; i < ne && i < 1024; i++) begin
        ea = AW'((b + i) % MEMSZ);
        if (bad < 0 && addr_log[g][i] !== ea) bad = i;
      end
      checks++;
      if (addr_cnt[g] != ne || bad >= 0) begin
        failures++;
        $display("FAIL addr_seq inst=%0d issued=%0d required=%0d first_bad_index=%0d", g, addr_cnt[g], ne, bad);
      end
`ifdef WL_CHECKSUM_EN
      checks++;
      if (checksum[g] !== exp_sum) begin
        failures++;
        $display("FAIL checksum inst=%0d got=%0d required=%0d", g, checksum[g], exp_sum);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_load();
    bit hit;
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(1234);
    num_words = CW'(640);
    @(posedge clk);
    #1;
    start = 1'b0;
    hit   = 1'b0;
    for (int e = 0; e < 1000 && !hit; e++) begin
      @(posedge clk);
      #1;
      if (word_count[1] == CW'(100)) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL reset_mid_reach inst=1 cnt=%0d required=100", word_count[1]);
    end
    rst = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({bram_en[g], bram_addr[g], word_count[g], busy[g], done[g]} !== '0 || data_out[g] !== '0) begin
        failures++;
        $display("FAIL reset_mid_load inst=%0d en=%0b addr=%0d cnt=%0d busy=%0b done=%0b required all zero",
                 g, bram_en[g], bram_addr[g], word_count[g], busy[g], done[g]);
      end
`ifdef WL_CHECKSUM_EN
      checks++;
      if (checksum[g] !== '0) begin
        failures++;
        $display("FAIL reset_mid_checksum inst=%0d got=%0d required=0", g, checksum[g]);
      end
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({busy[g], done[g], bram_en[g]} !== 3'b000) begin
        failures++;
        $display("FAIL reset_no_partial_done inst=%0d busy=%0b done=%0b en=%0b required 0",
                 g, busy[g], done[g], bram_en[g]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    log_clr   = 1'b0;
    test_reset();
    test_load(16448, 640, -1, 0);
    test_load(5, 4, -1, 3);
    test_load(16448, 0, -1, 0);
    test_load(32765, 6, -1, 0);
    test_load(100, 20, 10, 2);
    test_load(200, 1000, -1, 3);
    test_load(0, 1, -1, 3);
    test_reset_mid_load();
    test_load(16448, 640, -1, 0);
    test_load(7, 640, -1, 1);
    for (int r = 0; r < 6; r++) begin
      test_load(int'($urandom_range(0, MEMSZ - 1)), int'($urandom_range(0, 700)), -1, 2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
